// File: rtl/cpt_search.sv
// cpt_search: sequential initiator for the equality comparator.
// Walks candidate words from a base value onto the comparator B input,
// one per clock, and reports the first candidate that matches A (or that
// none did, or that the search was aborted).
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for start; search results held from last search
// S_SCAN | one candidate on cand_o per cycle, eq_i sampled each cycle
// S_DONE | one-cycle done pulse, then back to S_IDLE
module cpt_search #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [WIDTH-1:0] base_i,
  input  logic             eq_i,
  output logic [WIDTH-1:0] cand_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             found_o,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH:0]   tries_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // tries counts candidates already evaluated, so the last candidate is
  // the one seen while tries still equals 2^WIDTH-1.
  localparam logic [WIDTH:0]   LAST_TRY  = {1'b0, {WIDTH{1'b1}}};
  localparam logic [WIDTH:0]   ALL_TRIES = {1'b1, {WIDTH{1'b0}}};
  localparam logic [WIDTH-1:0] CAND_STEP = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH:0]   TRY_STEP  = {{WIDTH{1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH:0]   tries_q, tries_d;
  logic             found_q, found_d;

  // State and datapath registers, cleared immediately by reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cand_q   <= '0;
      result_q <= '0;
      tries_q  <= '0;
      found_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      result_q <= result_d;
      tries_q  <= tries_d;
      found_q  <= found_d;
    end
  end

  // Next-state and datapath update; everything holds unless a transition
  // says otherwise, which keeps results stable through DONE and IDLE.
  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    result_d = result_q;
    tries_d  = tries_q;
    found_d  = found_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          cand_d  = base_i;
          tries_d = '0;
          found_d = 1'b0;
          state_d = S_SCAN;
        end
      end

      S_SCAN: begin
        if (abort_i) begin
          found_d = 1'b0;
          state_d = S_DONE;
        end else if (eq_i) begin
          found_d  = 1'b1;
          result_d = cand_q;
          tries_d  = tries_q + TRY_STEP;
          state_d  = S_DONE;
        end else if (tries_q == LAST_TRY) begin
          found_d = 1'b0;
          tries_d = ALL_TRIES;
          state_d = S_DONE;
        end else begin
          // Natural wrap of the WIDTH-bit add covers 2^WIDTH-1 -> 0.
          cand_d  = cand_q + CAND_STEP;
          tries_d = tries_q + TRY_STEP;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign cand_o   = cand_q;
  assign busy_o   = (state_q == S_SCAN);
  assign done_o   = (state_q == S_DONE);
  assign found_o  = found_q;
  assign result_o = result_q;
  assign tries_o  = tries_q;

endmodule
